// File: rtl/xcfi_mem_responder.sv
// Memory-side responder for the req/gnt/recv/ack interface: word RAM plus in-order response FIFO.
// Optional random grant/response stalls via `define XCFI_MEM_STALL_EN.
module xcfi_mem_responder #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_wen,
  input  logic [3:0]  mem_strb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic        mem_gnt,
  output logic        mem_recv,
  input  logic        mem_ack,
  output logic        mem_error,
  output logic [31:0] mem_rdata
);

  localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  // Elaboration-time parameter sanity checks
  if (MEM_WORDS == 0 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_words
    $error("MEM_WORDS must be a non-zero power of two");
  end
  if (DEPTH == 0 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 1");
  end
  if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
    $error("BASE_ADDR must be word aligned");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("LFSR_SEED must be non-zero");
  end

  logic [31:0]      ram_q [MEM_WORDS];
  logic [31:0]      fifo_data_q [DEPTH];
  logic             fifo_err_q  [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0]      off_c;
  logic [29:0]      word_c;
  logic [IDX_W-1:0] ram_idx_c;
  logic             err_c;
  logic             full_c;
  logic             empty_c;
  logic             accept_c;
  logic             pop_c;
  logic             wr_en_c;
  logic [31:0]      push_data_c;

  // Address decode; BASE_ADDR is aligned so the offset's low bits mirror the address.
  always_comb begin
    off_c     = mem_addr - BASE_ADDR;
    word_c    = off_c[31:2];
    ram_idx_c = word_c[IDX_W-1:0];
    err_c     = (off_c[1:0] != 2'b00) || (32'(word_c) >= MEM_WORDS);
  end

  assign full_c   = (count_q == DEPTH_C);
  assign empty_c  = (count_q == '0);
  assign accept_c = mem_req & mem_gnt;
  assign pop_c    = mem_recv & mem_ack;
  assign wr_en_c  = accept_c & mem_wen & ~err_c & ~reset;

  // Reads see the RAM before this edge's write; writes and errors return zero data.
  always_comb begin
    push_data_c = '0;
    if (!err_c && !mem_wen) begin
      push_data_c = ram_q[ram_idx_c];
    end
  end

  // Byte-strobed RAM write; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (wr_en_c) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_strb[b]) begin
          ram_q[ram_idx_c][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept_c) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({accept_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (accept_c && !reset) begin
      fifo_data_q[wr_ptr_q] <= push_data_c;
      fifo_err_q[wr_ptr_q]  <= err_c;
    end
  end

`ifdef XCFI_MEM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        hold_q, hold_d;

  // Fibonacci LFSR, taps 16,14,13,11
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    hold_d = mem_recv & ~mem_ack;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
      hold_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      hold_q <= hold_d;
    end
  end

  // Once presented, a response stays valid until acked regardless of the LFSR.
  assign mem_gnt  = ~full_c & lfsr_q[0];
  assign mem_recv = hold_q | (~empty_c & lfsr_q[1]);
`else
  assign mem_gnt  = ~full_c;
  assign mem_recv = ~empty_c;
`endif

  assign mem_rdata = mem_recv ? fifo_data_q[rd_ptr_q] : '0;
  assign mem_error = mem_recv ? fifo_err_q[rd_ptr_q]  : 1'b0;

endmodule

// File: tb/tb_xcfi_mem_responder.sv
// Directed bench for xcfi_mem_responder (default build: no stalls, DEPTH=2, 1024 words at 0).
module tb_xcfi_mem_responder;

  logic        clock;
  logic        reset;
  logic        mem_req;
  logic        mem_wen;
  logic [3:0]  mem_strb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_recv;
  logic        mem_ack;
  logic        mem_error;
  logic [31:0] mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  xcfi_mem_responder #(
    .MEM_WORDS(1024),
    .BASE_ADDR(32'h0000_0000),
    .DEPTH(2),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .mem_req(mem_req),
    .mem_wen(mem_wen),
    .mem_strb(mem_strb),
    .mem_wdata(mem_wdata),
    .mem_addr(mem_addr),
    .mem_gnt(mem_gnt),
    .mem_recv(mem_recv),
    .mem_ack(mem_ack),
    .mem_error(mem_error),
    .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        req;
    logic        wen;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic        ack;
    logic        gnt;
    logic        recv;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic req, input logic wen, input logic [3:0] strb,
                     input logic [31:0] wdata, input logic [31:0] addr, input logic ack,
                     input logic gnt, input logic recv, input logic err, input logic [31:0] rdata);
    vec_t v;
    v.req = req; v.wen = wen; v.strb = strb; v.wdata = wdata; v.addr = addr; v.ack = ack;
    v.gnt = gnt; v.recv = recv; v.err = err; v.rdata = rdata;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic req, input logic wen, input logic [3:0] strb,
                       input logic [31:0] wdata, input logic [31:0] addr, input logic ack);
    mem_req = req; mem_wen = wen; mem_strb = strb; mem_wdata = wdata; mem_addr = addr;
    mem_ack = ack;
  endtask

  task automatic cmp(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %09h, expected %09h", name, act, exp);
    end
  endtask

  // Outputs packed as {gnt, recv, err, rdata}
  function automatic logic [35:0] outs();
    return {1'b0, mem_gnt, mem_recv, mem_error, mem_rdata};
  endfunction

  // Issue one read and wait (bounded) for its response; entered and left on a falling edge.
  task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    int lat;
    drive(1'b1, 1'b0, 4'h0, 32'h0, addr, 1'b0);
    cmp({name, "_gnt"}, 36'(mem_gnt), 36'd1);
    @(negedge clock);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    lat = 1;
    while (!mem_recv && lat < 8) begin
      @(negedge clock);
      lat++;
    end
    if (!mem_recv) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: no response after %0d cycles", name, lat);
    end else begin
      cmp({name, "_lat"}, 36'(lat), 36'd1);
      cmp({name, "_data"}, {3'b0, mem_error, mem_rdata}, {4'b0, exp});
      mem_ack = 1'b1;
      @(negedge clock);
      mem_ack = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // req wen strb wdata addr ack | gnt recv err rdata
    add(0, 0, 4'h0, 32'h0,         32'h0000_0000, 0,  1, 0, 0, 32'h0);
    add(1, 1, 4'hF, 32'hDEADBEEF,  32'h0000_0010, 1,  1, 0, 0, 32'h0);
    add(1, 0, 4'h0, 32'h0,         32'h0000_0010, 1,  1, 1, 0, 32'h0);
    add(1, 1, 4'h2, 32'h0000_5500, 32'h0000_0010, 1,  1, 1, 0, 32'hDEADBEEF);
    add(1, 0, 4'h0, 32'h0,         32'h0000_0010, 1,  1, 1, 0, 32'h0);
    add(1, 0, 4'h0, 32'h0,         32'h0000_0012, 1,  1, 1, 0, 32'hDEAD55EF);
    add(1, 0, 4'h0, 32'h0,         32'h0000_1000, 1,  1, 1, 1, 32'h0);
    add(1, 1, 4'hF, 32'h0,         32'h0000_0011, 1,  1, 1, 1, 32'h0);
    add(1, 0, 4'h0, 32'h0,         32'hFFFF_FFFC, 1,  1, 1, 1, 32'h0);
    add(1, 1, 4'h0, 32'hFFFFFFFF,  32'h0000_0010, 1,  1, 1, 1, 32'h0);
    add(1, 0, 4'h0, 32'h0,         32'h0000_0010, 1,  1, 1, 0, 32'h0);
    add(0, 1, 4'hF, 32'h12345678,  32'h0000_0010, 1,  1, 1, 0, 32'hDEAD55EF);
    add(1, 1, 4'hF, 32'h11111111,  32'h0000_0000, 0,  1, 0, 0, 32'h0);
    add(1, 1, 4'hF, 32'h22222222,  32'h0000_0004, 1,  1, 1, 0, 32'h0);
    add(0, 0, 4'h0, 32'h0,         32'h0000_0000, 1,  1, 1, 0, 32'h0);
    // Fill the two-entry FIFO with acks held low
    add(1, 0, 4'h0, 32'h0,         32'h0000_0000, 0,  1, 0, 0, 32'h0);
    add(1, 0, 4'h0, 32'h0,         32'h0000_0004, 0,  1, 1, 0, 32'h11111111);
    add(1, 0, 4'h0, 32'h0,         32'h0000_0010, 0,  0, 1, 0, 32'h11111111);
    add(1, 0, 4'h0, 32'h0,         32'h0000_0010, 1,  0, 1, 0, 32'h11111111);
    add(1, 0, 4'h0, 32'h0,         32'h0000_0010, 0,  1, 1, 0, 32'h22222222);
    add(0, 0, 4'h0, 32'h0,         32'h0000_0000, 1,  0, 1, 0, 32'h22222222);
    add(0, 0, 4'h0, 32'h0,         32'h0000_0000, 1,  1, 1, 0, 32'hDEAD55EF);
    add(0, 0, 4'h0, 32'h0,         32'h0000_0000, 1,  1, 0, 0, 32'h0);
    // Last valid word
    add(1, 1, 4'hF, 32'hA5A5A5A5,  32'h0000_0FFC, 1,  1, 0, 0, 32'h0);
    add(1, 0, 4'h0, 32'h0,         32'h0000_0FFC, 1,  1, 1, 0, 32'h0);
    add(0, 0, 4'h0, 32'h0,         32'h0000_0000, 1,  1, 1, 0, 32'hA5A5A5A5);
    add(0, 0, 4'h0, 32'h0,         32'h0000_0000, 0,  1, 0, 0, 32'h0);

    reset = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].req, vecs[i].wen, vecs[i].strb, vecs[i].wdata, vecs[i].addr, vecs[i].ack);
      cmp($sformatf("vec%0d", i), outs(),
          {1'b0, vecs[i].gnt, vecs[i].recv, vecs[i].err, vecs[i].rdata});
      @(negedge clock);
    end

    // Reset with responses outstanding and a write accepted in the reset cycle
    drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0000_0000, 1'b0);
    cmp("rst_pre0", outs(), {4'b0100, 32'h0});
    @(negedge clock);
    reset = 1'b1;
    drive(1'b1, 1'b1, 4'hF, 32'hBAD0BAD0, 32'h0000_0000, 1'b0);
    cmp("rst_pre1", outs(), {4'b0110, 32'h11111111});
    @(negedge clock);
    reset = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    cmp("rst_post", outs(), {4'b0100, 32'h0});
    @(negedge clock);

    rd_check("rd_w0", 32'h0000_0000, 32'h11111111);
    rd_check("rd_w1", 32'h0000_0004, 32'h22222222);
    rd_check("rd_w4", 32'h0000_0010, 32'hDEAD55EF);
    rd_check("rd_last", 32'h0000_0FFC, 32'hA5A5A5A5);
    cmp("idle_end", outs(), {4'b0100, 32'h0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/xcfi_mem_responder.md
# xcfi_mem_responder

Memory-side responder for the core's `req`/`gnt`/`recv`/`ack` memory interface, usable on either the instruction or data port. Accepts requests, services them from an internal word-addressed RAM, and returns in-order responses through a small outstanding-response FIFO. It replaces free-running `$anyseq` memory inputs in simulation and bounded-proof benches where real load/store data is needed.

## Interface
- `MEM_WORDS`, 1024: RAM depth in 32-bit words; power of two.
- `BASE_ADDR`, 32'h0000_0000: byte address of RAM word 0; word-aligned.
- `DEPTH`, 2: outstanding-response FIFO depth; power of two, ≥1.
- `LFSR_SEED`, 16'hACE1: stall LFSR reset value; non-zero. Used only with stall feature.

- `clock`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_req`  in  1  initiator request valid.
- `mem_wen`  in  1  1 = write, 0 = read.
- `mem_strb`  in  4  write byte strobes; bit i covers `mem_wdata[8i+7:8i]`.
- `mem_wdata`  in  32  write data.
- `mem_addr`  in  32  byte address.
- `mem_gnt`  out  1  request accepted this cycle when `mem_req && mem_gnt`.
- `mem_recv`  out  1  response valid.
- `mem_ack`  in  1  initiator accepts response; completes when `mem_recv && mem_ack`.
- `mem_error`  out  1  response carries bus error.
- `mem_rdata`  out  32  response read data.

## Operation
- Accept: `accept = mem_req && mem_gnt`. `mem_gnt = !full` (combinational from registered FIFO count; no fall-through of a same-cycle pop).
- Decode at accept: `off = mem_addr - BASE_ADDR` (32-bit, wraps); `idx = off >> 2`. Error if `mem_addr[1:0] != 0` or `idx >= MEM_WORDS`.
- Write, no error: bytes with `mem_strb[i]` set written to `ram[idx]` at the accept edge; response rdata = 0. `mem_strb == 0` is a legal no-op write.
- Read, no error: response rdata = `ram[idx]` sampled at accept, after all earlier-accepted writes.
- Error: RAM untouched; response rdata = 0, error = 1.
- Each accept pushes `{error, rdata}` into FIFO. Responses returned strictly in accept order.
- Response: `mem_recv = !empty`; `mem_rdata`/`mem_error` = FIFO head. Head held stable until `mem_recv && mem_ack`, then popped.
- Push and pop in same cycle: both take effect; count unchanged. Push when full is impossible (gnt low).
- Pointers wrap modulo `DEPTH`; count width `$clog2(DEPTH)+1`.
- RAM contents zero at time 0; not cleared by reset.
- `mem_ack` without `mem_recv` ignored. `mem_wen`/`mem_strb`/`mem_wdata`/`mem_addr` ignored when `!mem_req`.

## Timing
- Reset values: `mem_gnt`=1 (0 possible only under stall feature per LFSR), `mem_recv`=0, `mem_error`=0, `mem_rdata`=0; FIFO empty.
- Latency: accept in cycle N → `mem_recv` earliest N+1. Back-to-back accepts every cycle while FIFO not full and initiator acks every cycle.
- With `DEPTH`=2 and no acks: two accepts, then `mem_gnt`=0 until first pop; `mem_gnt` returns the cycle after the pop edge.
- Reset mid-operation: FIFO and outstanding responses discarded; write accepted in the reset cycle is not performed; already-written RAM data retained.

## Configuration
- `XCFI_MEM_STALL_EN` defined: 16-bit Fibonacci LFSR (taps 16,14,13,11), reset to `LFSR_SEED`, advances every cycle. `mem_gnt = !full && lfsr[0]`. A new head is presented (`mem_recv` rises) only when `lfsr[1]`; once `mem_recv` is high it stays high and stable until acked regardless of LFSR.
- Not defined: no LFSR; `mem_gnt = !full`, `mem_recv = !empty`, behaviour as above.

## Test plan
- Write `addr`=0x10, `wdata`=0xDEADBEEF, strb=4'hF; then read 0x10 → recv one cycle after accept, `mem_rdata`=0xDEADBEEF, error=0.
- Byte write strb=4'b0010, wdata=0x0000_5500 to 0x10; read 0x10 → 0xDEAD55EF.
- Read 0x12 (misaligned) and read `BASE_ADDR + 4*MEM_WORDS` → both error=1, rdata=0; RAM word 0x10 unchanged.
- `DEPTH`=2, reads at 0x0 and 0x4 with `mem_ack` held 0 → `mem_gnt`=0 from cycle after second accept; ack once → head pops, `mem_gnt`=1 next cycle; responses in order.
- Continuous req, ack tied 1 → one accept and one completion per cycle, no bubbles after first response.
- Reset asserted with 2 responses outstanding → next cycle `mem_recv`=0, `mem_gnt`=1; previously written data still readable; with `XCFI_MEM_STALL_EN`, `mem_recv` never drops before ack over 10k random cycles.
